// File: rtl/seq_shifter_pkg.sv
// Shared types for the multi-cycle shifter: opcode and FSM state encodings.
// SEQ_SHIFTER_ROTATE_EN enables the ROL/ROR opcodes; otherwise they act as NONE.
package seq_shifter_pkg;

  typedef enum logic [2:0] {
    OP_NONE = 3'b000,
    OP_LSL  = 3'b001,
    OP_LSR  = 3'b010,
    OP_ASR  = 3'b011,
    OP_ROL  = 3'b100,
    OP_ROR  = 3'b101,
    OP_RSV6 = 3'b110,
    OP_RSV7 = 3'b111
  } shift_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } shift_state_e;

  // True when the opcode moves bits; everything else collapses to NONE.
  function automatic logic op_active(input logic [2:0] op);
    logic act;
    act = (op == OP_LSL) || (op == OP_LSR) || (op == OP_ASR);
`ifdef SEQ_SHIFTER_ROTATE_EN
    act = act || (op == OP_ROL) || (op == OP_ROR);
`endif
    return act;
  endfunction

endpackage

// File: rtl/seq_shifter_step.sv
// Combinational single-step shift unit: applies k positions of one operation.
// Rotate paths exist only when SEQ_SHIFTER_ROTATE_EN is defined.
module shift_step
  import seq_shifter_pkg::*;
#(
  parameter int WIDTH = 16,
  localparam int AMT_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] value,
  input  shift_op_e        op,
  input  logic [AMT_W-1:0] k,
  output logic [WIDTH-1:0] result,
  output logic             carry
);

  logic [WIDTH-1:0] out_hi;
  logic [WIDTH-1:0] out_lo;
`ifdef SEQ_SHIFTER_ROTATE_EN
  logic [WIDTH-1:0] rot_l;
  logic [WIDTH-1:0] rot_r;
`endif

  always_comb begin
    // Bit 0 of out_hi is value[WIDTH-k]; bit 0 of out_lo is value[k-1].
    out_hi = value >> (WIDTH - int'(k));
    out_lo = value >> (k - AMT_W'(1));
`ifdef SEQ_SHIFTER_ROTATE_EN
    rot_l  = (value << k) | (value >> (WIDTH - int'(k)));
    rot_r  = (value >> k) | (value << (WIDTH - int'(k)));
`endif
    result = value;
    carry  = 1'b0;
    case (op)
      OP_LSL: begin result = value << k;            carry = out_hi[0]; end
      OP_LSR: begin result = value >> k;            carry = out_lo[0]; end
      OP_ASR: begin result = $signed(value) >>> k;  carry = out_lo[0]; end
`ifdef SEQ_SHIFTER_ROTATE_EN
      OP_ROL: begin result = rot_l; carry = rot_l[0];       end
      OP_ROR: begin result = rot_r; carry = rot_r[WIDTH-1]; end
`endif
      default: ;
    endcase
    if (k == '0) carry = 1'b0;
  end

endmodule

// File: rtl/seq_shifter.sv
// Multi-cycle shifter: up to STEP positions per clock behind valid/ready.
// Build option SEQ_SHIFTER_ROTATE_EN enables ROL/ROR (see shift_step).
module seq_shifter
  import seq_shifter_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int STEP  = 1,
  localparam int AMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [2:0]       in_op,
  input  logic [AMT_W-1:0] in_amt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_carry,
  output logic             out_zero,
  output shift_state_e     dbg_state
);

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both high; in_ready only in IDLE, out_valid only in DONE, so an accept
  // and a release can never share a cycle.
  localparam logic [AMT_W-1:0] STEP_K = AMT_W'(STEP);

  shift_state_e     state_q, state_d;
  logic [WIDTH-1:0] data_q,  data_d;
  shift_op_e        op_q,    op_d;
  logic [AMT_W-1:0] rem_q,   rem_d;
  logic             carry_q, carry_d;

  logic [AMT_W-1:0] step_k;
  logic [WIDTH-1:0] step_val;
  logic             step_carry;

  assign step_k = (rem_q < STEP_K) ? rem_q : STEP_K;

  shift_step #(.WIDTH(WIDTH)) u_step (
    .value  (data_q),
    .op     (op_q),
    .k      (step_k),
    .result (step_val),
    .carry  (step_carry)
  );

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    op_d    = op_q;
    rem_d   = rem_q;
    carry_d = carry_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          data_d  = in_data;
          op_d    = op_active(in_op) ? shift_op_e'(in_op) : OP_NONE;
          rem_d   = in_amt;
          carry_d = 1'b0;
          state_d = (in_amt == '0 || !op_active(in_op)) ? ST_DONE : ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        data_d  = step_val;
        carry_d = step_carry;
        rem_d   = rem_q - step_k;
        if (rem_d == '0) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      data_q  <= '0;
      op_q    <= OP_NONE;
      rem_q   <= '0;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      op_q    <= op_d;
      rem_q   <= rem_d;
      carry_q <= carry_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign out_data  = data_q;
  assign out_carry = carry_q;
  assign out_zero  = (data_q == '0);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_seq_shifter.sv
// Bench for seq_shifter: directed cases plus random ops against a whole-amount
// reference model; a second instance with STEP=4 checks multi-bit stepping.
module tb_seq_shifter;
  import seq_shifter_pkg::*;

  localparam int W     = 16;
  localparam int AMT_W = $clog2(W);

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic             in_valid = 1'b0, out_ready = 1'b0;
  logic [W-1:0]     in_data = '0;
  logic [2:0]       in_op = '0;
  logic [AMT_W-1:0] in_amt = '0;
  logic             in_ready, out_valid, out_carry, out_zero;
  logic [W-1:0]     out_data;
  shift_state_e     dbg_state;

  logic             in_valid4 = 1'b0, out_ready4 = 1'b0;
  logic [W-1:0]     in_data4 = '0;
  logic [2:0]       in_op4 = '0;
  logic [AMT_W-1:0] in_amt4 = '0;
  logic             in_ready4, out_valid4, out_carry4, out_zero4;
  logic [W-1:0]     out_data4;
  shift_state_e     dbg_state4;

  seq_shifter #(.WIDTH(W), .STEP(1)) u_dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_op(in_op), .in_amt(in_amt), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_carry(out_carry),
    .out_zero(out_zero), .dbg_state(dbg_state)
  );

  seq_shifter #(.WIDTH(W), .STEP(4)) u_dut4 (
    .clk(clk), .reset(reset), .in_valid(in_valid4), .in_ready(in_ready4),
    .in_data(in_data4), .in_op(in_op4), .in_amt(in_amt4), .out_valid(out_valid4),
    .out_ready(out_ready4), .out_data(out_data4), .out_carry(out_carry4),
    .out_zero(out_zero4), .dbg_state(dbg_state4)
  );

  int n_vec = 0;
  int n_err = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Whole-operation reference: shift by the full amount at once.
  task automatic model(input logic [2:0] op, input logic [W-1:0] d, input int amt,
                       input int step, output logic [W-1:0] r, output logic c,
                       output int lat);
    logic [2*W-1:0] dd;
    logic [W-1:0]   tmp;
    logic           act;
    act = (op == 3'd1) || (op == 3'd2) || (op == 3'd3);
`ifdef SEQ_SHIFTER_ROTATE_EN
    act = act || (op == 3'd4) || (op == 3'd5);
`endif
    r = d; c = 1'b0; lat = 1;
    if (act && amt != 0) begin
      lat = 1 + (amt + step - 1) / step;
      case (op)
        3'd1: begin r = d << amt; tmp = d >> (W - amt); c = tmp[0]; end
        3'd2: begin r = d >> amt; tmp = d >> (amt - 1); c = tmp[0]; end
        3'd3: begin r = $signed(d) >>> amt; tmp = d >> (amt - 1); c = tmp[0]; end
        3'd4: begin dd = {d, d} << amt; r = dd[2*W-1:W]; c = r[0]; end
        default: begin dd = {d, d} >> amt; r = dd[W-1:0]; c = r[W-1]; end
      endcase
    end
  endtask

  task automatic run_op(input logic [2:0] op, input logic [W-1:0] d, input int amt,
                        input int hold);
    logic [W-1:0] er, exp_d;
    logic         ec;
    int           el, lat;
    model(op, d, amt, 1, er, ec, el);
    exp_q.push_back(er);
    @(negedge clk);
    check("idle_in_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b1; in_data = d; in_op = op; in_amt = AMT_W'(amt);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    do begin @(negedge clk); lat++; end while (!out_valid && lat < 64);
    check("latency", 32'(lat), 32'(el));
    exp_d = exp_q.pop_front();
    check("data", 32'(out_data), 32'(exp_d));
    check("carry", 32'(out_carry), 32'(ec));
    check("zero", 32'(out_zero), 32'(exp_d == '0));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_data", 32'(out_data), 32'(exp_d));
      check("hold_carry", 32'(out_carry), 32'(ec));
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(negedge clk);
    check("release_valid", 32'(out_valid), 32'd0);
    check("release_in_ready", 32'(in_ready), 32'd1);
  endtask

  task automatic run_op4(input logic [2:0] op, input logic [W-1:0] d, input int amt);
    logic [W-1:0] er;
    logic         ec;
    int           el, lat;
    model(op, d, amt, 4, er, ec, el);
    @(negedge clk);
    in_valid4 = 1'b1; in_data4 = d; in_op4 = op; in_amt4 = AMT_W'(amt);
    @(posedge clk); #1;
    in_valid4 = 1'b0;
    lat = 0;
    do begin @(negedge clk); lat++; end while (!out_valid4 && lat < 64);
    check("s4_latency", 32'(lat), 32'(el));
    check("s4_data", 32'(out_data4), 32'(er));
    check("s4_carry", 32'(out_carry4), 32'(ec));
    out_ready4 = 1'b1;
    @(posedge clk); #1;
    out_ready4 = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_carry", 32'(out_carry), 32'd0);
    check("rst_out_zero", 32'(out_zero), 32'd1);
    check("rst_s4_valid", 32'(out_valid4), 32'd0);

    run_op(3'd0, 16'hF0CF, 1, 0);
    run_op(3'd1, 16'hF0CF, 1, 0);
    run_op(3'd2, 16'hF0CF, 1, 0);
    run_op(3'd3, 16'hF0CF, 1, 0);
    run_op(3'd5, 16'hF0CF, 4, 0);
    run_op(3'd4, 16'hF0CF, 4, 0);
    run_op(3'd6, 16'h1234, 7, 0);
    run_op(3'd7, 16'h8001, 3, 0);
    run_op(3'd3, 16'h8000, 15, 0);
    run_op(3'd1, 16'h0000, 0, 0);
    run_op(3'd2, 16'hA5A5, 6, 5);

    run_op4(3'd3, 16'h8000, 15);
    run_op4(3'd1, 16'hF0CF, 9);
    run_op4(3'd2, 16'h8421, 4);

    // Reset in the middle of a long shift discards it.
    @(negedge clk);
    in_valid = 1'b1; in_data = 16'hFFFF; in_op = 3'd2; in_amt = AMT_W'(10);
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_out_data", 32'(out_data), 32'd0);
    check("midrst_out_zero", 32'(out_zero), 32'd1);
    run_op(3'd2, 16'h0004, 2, 0);

    for (int i = 0; i < 40; i++) begin
      run_op(3'($urandom_range(0, 7)), W'($urandom), $urandom_range(0, W - 1),
             $urandom_range(0, 2));
    end
    for (int i = 0; i < 10; i++) begin
      run_op4(3'($urandom_range(0, 7)), W'($urandom), $urandom_range(0, W - 1));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
